delta_adc_multi: RTL and testbench

DELTA_ADC_MULTI -- requirements
Module: delta_adc_multi

---
 rtl/delta_adc_multi.sv | 164 ++++++++++++++++
 tb/tb_delta_adc_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/delta_adc_multi.sv
// Multi-channel delta modulator ADC front end.
// Each channel tracks an external comparator with a saturating DAC code
// (linear or adaptive step). Every tick queues one sample per channel; a
// round-robin result stage drains samples with valid/ready handshaking.
module delta_adc_multi #(
    parameter int CH   = 4,
    parameter int W    = 8,
    parameter int DIV  = 16,
    parameter int EMAX = 3,
    localparam int CW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [CH-1:0]   cmp_in,
    output logic [CH*W-1:0] dac_code,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_chan,
    output logic [CH-1:0]   overrun,
    input  logic            clear_ovr
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW = (EMAX > 0) ? $clog2(EMAX + 1) : 1;
    // Arithmetic width: room for code plus the largest step without overflow.
    localparam int SW = W + EMAX + 2;

    logic [PW-1:0] cnt;
    logic          tick;
    logic [W-1:0]  code_arr [CH];

    // Prescaler: counts while enabled, parked at zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!en)
            cnt <= '0;
        else if (cnt == PW'(DIV - 1))
            cnt <= '0;
        else
            cnt <= cnt + PW'(1);
    end

    assign tick = en && (cnt == PW'(DIV - 1));

    // Per-channel tracking loop.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [EW-1:0] e_q, e_n;
        logic          prev_q;
        logic [W-1:0]  code_q, code_n;
        logic [SW-1:0] step, cext, sum;

        // Next exponent, step size and saturated code for this channel.
        always_comb begin
            e_n    = '0;
            step   = '0;
            cext   = SW'(code_q);
            sum    = '0;
            code_n = code_q;
            if (mode) begin
                if (cmp_in[i] == prev_q)
                    e_n = (e_q >= EW'(EMAX)) ? EW'(EMAX) : e_q + EW'(1);
                else
                    e_n = '0;
            end
            step = SW'(1) << e_n;
            if (cmp_in[i]) begin
                sum = cext + step;
                if (sum > SW'({W{1'b1}}))
                    code_n = {W{1'b1}};
                else
                    code_n = sum[W-1:0];
            end else begin
                if (cext < step) begin
                    code_n = '0;
                end else begin
                    sum    = cext - step;
                    code_n = sum[W-1:0];
                end
            end
        end

        // Channel state advances only on ticks; code starts mid-scale.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                e_q    <= '0;
                prev_q <= 1'b0;
                code_q <= W'(1) << (W - 1);
            end else if (tick) begin
                e_q    <= e_n;
                prev_q <= cmp_in[i];
                code_q <= code_n;
            end
        end

        assign dac_code[i*W +: W] = code_q;
        assign code_arr[i]        = code_q;
    end

    logic [CH-1:0] pending;
    logic [CH-1:0] take;
    logic [CH-1:0] ovr_set;
    logic [CW-1:0] ptr;
    logic [CW-1:0] sel;
    logic          found;
    logic          load;
    int            idx;

    // Round-robin pick: first pending channel after the last one loaded.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = 0;
        for (int k = 1; k <= CH; k++) begin
            idx = (int'(ptr) + k) % CH;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
    end

    assign load    = !out_valid || out_ready;
    assign take    = (load && found) ? (CH'(1) << sel) : '0;
    // A tick on a still-pending (and not now loaded) channel loses a sample.
    assign ovr_set = tick ? (pending & ~take) : '0;

    // Pending set by tick wins over the clear from a same-cycle load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending & ~take) | {CH{tick}};
    end

    // Sticky overrun flags; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun <= '0;
        else
            overrun <= (clear_ovr ? '0 : overrun) | ovr_set;
    end

    // Result stage: holds its sample until accepted, refills every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= CW'(CH - 1);
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= code_arr[sel];
                out_chan <= sel;
                ptr      <= sel;
            end
        end
    end

endmodule

// File: tb/tb_delta_adc_multi.sv
// Directed bench for delta_adc_multi with CH=4, W=8, DIV=4, EMAX=3.
module tb_delta_adc_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [3:0]  cmp_in;
    logic [31:0] dac_code;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic [3:0]  overrun;
    logic        clear_ovr;

    int checks = 0;
    int errors = 0;

    delta_adc_multi #(.CH(4), .W(8), .DIV(4), .EMAX(3)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .cmp_in(cmp_in),
        .dac_code(dac_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .overrun(overrun),
        .clear_ovr(clear_ovr)
    );

    always #5 clk = ~clk;

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset with idle inputs; returns on a negedge with rst low.
    task automatic do_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; cmp_in = 4'b0;
        out_ready = 1'b0; clear_ovr = 1'b0;
        run(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dac_code !== 32'h80808080) begin errors++; $display("FAIL reset_code got %h want 80808080", dac_code); end
        checks++;
        if ({out_valid, out_chan, out_data, overrun} !== 15'd0) begin errors++;
            $display("FAIL reset_outs got v=%b c=%0d d=%0d o=%b want zeros", out_valid, out_chan, out_data, overrun); end
        // en low: no ticks, codes stay put
        cmp_in = 4'b1111; out_ready = 1'b1;
        run(12);
        checks++;
        if (dac_code !== 32'h80808080 || out_valid !== 1'b0) begin errors++;
            $display("FAIL en_hold got %h v=%b want 80808080 v=0", dac_code, out_valid); end
    endtask

    task automatic test_linear();
        logic [7:0] exp0 [3];
        logic [7:0] exp1 [3];
        exp0 = '{8'd129, 8'd130, 8'd131};
        exp1 = '{8'd127, 8'd126, 8'd125};
        do_reset();
        mode = 1'b0; cmp_in = 4'b0001; out_ready = 1'b1; en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            run(4);
            checks++;
            if (dac_code[7:0] !== exp0[t]) begin errors++;
                $display("FAIL linear_ch0 tick%0d got %0d want %0d", t, dac_code[7:0], exp0[t]); end
            checks++;
            if (dac_code[15:8] !== exp1[t] || dac_code[31:24] !== exp1[t]) begin errors++;
                $display("FAIL linear_ch13 tick%0d got %0d/%0d want %0d", t, dac_code[15:8], dac_code[31:24], exp1[t]); end
        end
        run(2);
        checks++;
        if (overrun !== 4'b0) begin errors++; $display("FAIL linear_ovr got %b want 0000", overrun); end
    endtask

    task automatic test_adaptive();
        logic [7:0] exp0 [6];
        exp0 = '{8'd129, 8'd131, 8'd135, 8'd143, 8'd151, 8'd150};
        do_reset();
        mode = 1'b1; cmp_in = 4'b0001; out_ready = 1'b1; en = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (t == 5) cmp_in = 4'b0000;
            run(4);
            checks++;
            if (dac_code[7:0] !== exp0[t]) begin errors++;
                $display("FAIL adaptive_ch0 tick%0d got %0d want %0d", t, dac_code[7:0], exp0[t]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mode = 1'b1; cmp_in = 4'b0001; out_ready = 1'b1; en = 1'b1;
        run(4 * 25);
        checks++;
        if (dac_code[7:0] !== 8'd255) begin errors++; $display("FAIL sat_high got %0d want 255", dac_code[7:0]); end
        cmp_in = 4'b0000;
        run(4 * 40);
        checks++;
        if (dac_code[7:0] !== 8'd0) begin errors++; $display("FAIL sat_low got %0d want 0", dac_code[7:0]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] expd [4];
        expd = '{8'd127, 8'd129, 8'd127, 8'd129};
        do_reset();
        mode = 1'b0; cmp_in = 4'b1010; out_ready = 1'b1; en = 1'b1;
        run(4);
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            run(1);
            checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'(c) || out_data !== expd[c]) begin errors++;
                $display("FAIL rr_slot%0d got v=%b c=%0d d=%0d want v=1 c=%0d d=%0d",
                         c, out_valid, out_chan, out_data, c, expd[c]); end
        end
        run(1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got v=%b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        do_reset();
        mode = 1'b0; cmp_in = 4'b1111; out_ready = 1'b0; en = 1'b1;
        run(5);
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'd129) begin errors++;
            $display("FAIL bp_first got v=%b c=%0d d=%0d want v=1 c=0 d=129", out_valid, out_chan, out_data); end
        run(3);
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'd129) begin errors++;
            $display("FAIL bp_stable got v=%b c=%0d d=%0d want v=1 c=0 d=129", out_valid, out_chan, out_data); end
        checks++;
        if (overrun !== 4'b1110) begin errors++; $display("FAIL bp_ovr got %b want 1110", overrun); end
        en = 1'b0; clear_ovr = 1'b1;
        run(1);
        clear_ovr = 1'b0;
        checks++;
        if (overrun !== 4'b0000) begin errors++; $display("FAIL bp_clear got %b want 0000", overrun); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        mode = 1'b0; cmp_in = 4'b1111; out_ready = 1'b1; en = 1'b1;
        run(6);
        rst = 1'b1;
        #1;
        checks++;
        if (dac_code !== 32'h80808080 || {out_valid, out_chan, out_data, overrun} !== 15'd0) begin errors++;
            $display("FAIL mid_rst got code=%h v=%b c=%0d d=%0d o=%b want reset values",
                     dac_code, out_valid, out_chan, out_data, overrun); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run(1);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle cyc%0d got v=%b want 0", k, out_valid); end
        end
        run(2);
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'd129) begin errors++;
            $display("FAIL post_rst_first got v=%b c=%0d d=%0d want v=1 c=0 d=129", out_valid, out_chan, out_data); end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_adaptive();
        test_saturation();
        test_round_robin();
        test_backpressure();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
